sram_bank_arbiter: RTL and testbench

- Per-cycle arbiter that lets the 4 SIMT lanes share a 4-bank word-interleaved data SRAM (64 KB, 16K words, 4 × 4K-word banks).
- Each cycle, every bank grants at most one lane access, using a per-bank round-robin pointer.
- Conflicting lanes stall until granted. Read data returns one cycle after the grant.
- Sits between the lane load/store units and the bank storage macros.

---
 rtl/sram_bank_arbiter_if.sv | 33 +++
 rtl/sram_bank_arbiter.sv | 134 +++++++++++++
 tb/tb_sram_bank_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_bank_arbiter_if.sv
// Lane-side and bank-side bus bundle for the 4-lane / 4-bank SRAM arbiter.
// The master modport is the environment (lanes and bank macros); the slave modport is the arbiter.
interface sram_bank_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 32
);
  logic [3:0]          lane_req;
  logic [3:0]          lane_we;
  logic [4*AW-1:0]     lane_addr;
  logic [4*DW-1:0]     lane_wd;
  logic [3:0]          lane_gnt;
  logic [3:0]          lane_rvalid;
  logic [4*DW-1:0]     lane_rdata;
  logic [3:0]          bank_en;
  logic [3:0]          bank_we;
  logic [4*(AW-2)-1:0] bank_addr;
  logic [4*DW-1:0]     bank_wd;
  logic [4*DW-1:0]     bank_rd;

  modport master (
    output lane_req, lane_we, lane_addr, lane_wd,
    input  lane_gnt, lane_rvalid, lane_rdata,
    input  bank_en, bank_we, bank_addr, bank_wd,
    output bank_rd
  );

  modport slave (
    input  lane_req, lane_we, lane_addr, lane_wd,
    output lane_gnt, lane_rvalid, lane_rdata,
    output bank_en, bank_we, bank_addr, bank_wd,
    input  bank_rd
  );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Per-cycle round-robin arbiter sharing a 4-bank word-interleaved SRAM among 4 SIMT lanes.
// Optional stall statistics counter is built only when SRAM_BANK_ARB_STATS_EN is defined.
module sram_bank_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               reset,
  sram_bank_arbiter_if.slave bus,
  output logic [31:0]        conflict_cnt
);
  localparam int IW = AW - 2;

  logic [1:0]      lane_bank [4];
  logic [3:0]      cand      [4];
  logic [1:0]      ptr_q     [4];
  logic [1:0]      ptr_d     [4];
  logic [3:0]      win_vld;
  logic [1:0]      win_idx   [4];
  logic [3:0]      gnt;
  logic [3:0]      bank_en;
  logic [3:0]      bank_we;
  logic [4*IW-1:0] bank_addr;
  logic [4*DW-1:0] bank_wd;
  logic [3:0]      rvalid_q, rvalid_d;
  logic [4*DW-1:0] rdata_q, rdata_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_bank[i] = bus.lane_addr[i*AW +: 2];
    end
  end

  // Reset masks every candidate so no bank is touched while reset is held.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      cand[b] = '0;
      for (int i = 0; i < 4; i++) begin
        cand[b][i] = bus.lane_req[i] & ~reset & (lane_bank[i] == 2'(b));
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      win_vld[b] = 1'b0;
      win_idx[b] = '0;
      for (int k = 0; k < 4; k++) begin
        if (!win_vld[b] && cand[b][2'(ptr_q[b] + 2'(k))]) begin
          win_vld[b] = 1'b1;
          win_idx[b] = 2'(ptr_q[b] + 2'(k));
        end
      end
    end
  end

  always_comb begin
    gnt       = '0;
    bank_en   = '0;
    bank_we   = '0;
    bank_addr = '0;
    bank_wd   = '0;
    for (int b = 0; b < 4; b++) begin
      if (win_vld[b]) begin
        gnt[win_idx[b]]        = 1'b1;
        bank_en[b]             = 1'b1;
        bank_we[b]             = bus.lane_we[win_idx[b]];
        bank_addr[b*IW +: IW]  = bus.lane_addr[32'(win_idx[b])*AW + 2 +: IW];
        bank_wd[b*DW +: DW]    = bus.lane_wd[32'(win_idx[b])*DW +: DW];
      end
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      ptr_d[b] = win_vld[b] ? 2'(win_idx[b] + 2'd1) : ptr_q[b];
    end
    rvalid_d = gnt & ~bus.lane_we;
    rdata_d  = rdata_q;
    for (int i = 0; i < 4; i++) begin
      if (rvalid_d[i]) begin
        rdata_d[i*DW +: DW] = bus.bank_rd[32'(lane_bank[i])*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '{default: 2'd0};
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.lane_gnt    = gnt;
  assign bus.lane_rvalid = rvalid_q;
  assign bus.lane_rdata  = rdata_q;
  assign bus.bank_en     = bank_en;
  assign bus.bank_we     = bank_we;
  assign bus.bank_addr   = bank_addr;
  assign bus.bank_wd     = bank_wd;

`ifdef SRAM_BANK_ARB_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  stall_inc;
  logic [32:0] cnt_sum;

  // Saturating sum of lanes that requested but were not granted this cycle.
  always_comb begin
    stall_inc = 3'($countones(bus.lane_req & ~gnt));
    cnt_sum   = {1'b0, cnt_q} + 33'(stall_inc);
    cnt_d     = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (stall_inc != 3'd0) begin
        $display("bank conflict: %0d stalled lanes (req=%b gnt=%b)", stall_inc, bus.lane_req, gnt);
      end
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed self-checking bench for sram_bank_arbiter with a behavioural 4-bank SRAM model.
module tb_sram_bank_arbiter;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int IW = AW - 2;
`ifdef SRAM_BANK_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] conflict_cnt;

  logic          pl_en;
  logic [1:0]    pl_b;
  logic [IW-1:0] pl_i;
  logic [DW-1:0] pl_d;
  logic [DW-1:0] mem [4][4096];

  int n_checks = 0;
  int n_errors = 0;

  sram_bank_arbiter_if #(.AW(AW), .DW(DW)) sif();

  sram_bank_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (sif),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank macros: combinational read, write on the grant edge.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_b][pl_i] <= pl_d;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (sif.bank_en[b] && sif.bank_we[b]) begin
          mem[b][sif.bank_addr[b*IW +: IW]] <= sif.bank_wd[b*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    sif.bank_rd = '0;
    for (int b = 0; b < 4; b++) begin
      sif.bank_rd[b*DW +: DW] = mem[b][sif.bank_addr[b*IW +: IW]];
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] b, input logic [IW-1:0] i, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_b = b; pl_i = i; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_lane(input int i, input bit req, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    sif.lane_req[i]           = req;
    sif.lane_we[i]            = we;
    sif.lane_addr[i*AW +: AW] = addr;
    sif.lane_wd[i*DW +: DW]   = wd;
  endtask

  task automatic drop(input int i);
    sif.lane_req[i] = 1'b0;
  endtask

  task automatic cyc(input string tag, input logic [3:0] exp_gnt, input logic [3:0] exp_rv);
    @(negedge clk);
    chk({tag, "_gnt"}, 128'(sif.lane_gnt), 128'(exp_gnt));
    tick();
    chk({tag, "_rvalid"}, 128'(sif.lane_rvalid), 128'(exp_rv));
  endtask

  task automatic chk_rd(input string tag, input int i, input logic [DW-1:0] exp);
    chk(tag, 128'(sif.lane_rdata[i*DW +: DW]), 128'(exp));
  endtask

  task automatic reset_dut();
    sif.lane_req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pl_en = 1'b0; pl_b = '0; pl_i = '0; pl_d = '0;
    sif.lane_req = '0; sif.lane_we = '0; sif.lane_addr = '0; sif.lane_wd = '0;
    tick();
    preload(2'd0, 12'd0, 32'hA0);
    preload(2'd1, 12'd0, 32'hA1);
    preload(2'd2, 12'd0, 32'hA2);
    preload(2'd3, 12'd0, 32'hA3);
    preload(2'd0, 12'd1, 32'hB1);
    preload(2'd0, 12'd2, 32'hB2);
    preload(2'd0, 12'd3, 32'hB3);
    preload(2'd2, 12'd1, 32'hC1);
    preload(2'd2, 12'd2, 32'hC2);
    preload(2'd2, 12'd3, 32'hC3);
    chk("rst_rvalid", 128'(sif.lane_rvalid), 128'(4'b0000));
    chk("rst_rdata", 128'(sif.lane_rdata), 128'h0);
    chk("rst_cnt", 128'(conflict_cnt), 128'h0);
    reset = 1'b0;

    // No conflict: one lane per bank.
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 14'(i), 32'h0);
    @(negedge clk);
    chk("nc_gnt", 128'(sif.lane_gnt), 128'(4'b1111));
    chk("nc_bank_en", 128'(sif.bank_en), 128'(4'b1111));
    chk("nc_bank_we", 128'(sif.bank_we), 128'(4'b0000));
    chk("nc_bank_addr", 128'(sif.bank_addr), 128'h0);
    tick();
    chk("nc_rvalid", 128'(sif.lane_rvalid), 128'(4'b1111));
    chk("nc_rdata", 128'(sif.lane_rdata), 128'h000000A3_000000A2_000000A1_000000A0);
    sif.lane_req = '0;
    cyc("nc_idle", 4'b0000, 4'b0000);
    chk("nc_hold", 128'(sif.lane_rdata), 128'h000000A3_000000A2_000000A1_000000A0);
    chk("nc_cnt", 128'(conflict_cnt), 128'h0);

    // Full conflict on bank 0 from reset; each lane leaves after its grant.
    reset_dut();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 14'(4 * i), 32'h0);
    cyc("fc1", 4'b0001, 4'b0001); chk_rd("fc1_rd", 0, 32'hA0); drop(0);
    cyc("fc2", 4'b0010, 4'b0010); chk_rd("fc2_rd", 1, 32'hB1); drop(1);
    cyc("fc3", 4'b0100, 4'b0100); chk_rd("fc3_rd", 2, 32'hB2); drop(2);
    cyc("fc4", 4'b1000, 4'b1000); chk_rd("fc4_rd", 3, 32'hB3); drop(3);
    chk("fc_cnt", 128'(conflict_cnt), STATS ? 128'd6 : 128'd0);

    // Round-robin on bank 2: lane2 alone leaves ptr[2]=3.
    set_lane(2, 1'b1, 1'b0, 14'h6, 32'h0);
    cyc("rr_pre", 4'b0100, 4'b0100); chk_rd("rr_pre_rd", 2, 32'hC1); drop(2);
    set_lane(1, 1'b1, 1'b0, 14'hA, 32'h0);
    set_lane(3, 1'b1, 1'b0, 14'hE, 32'h0);
    cyc("rr_a", 4'b1000, 4'b1000); chk_rd("rr_a_rd", 3, 32'hC3); drop(3);
    cyc("rr_b", 4'b0010, 4'b0010); chk_rd("rr_b_rd", 1, 32'hC2);
    // ptr[2] now 2: a three-way contest must pick lane2, then lane3, then lane1.
    set_lane(2, 1'b1, 1'b0, 14'h6, 32'h0);
    set_lane(3, 1'b1, 1'b0, 14'hE, 32'h0);
    cyc("rr_c", 4'b0100, 4'b0100); drop(2);
    cyc("rr_d", 4'b1000, 4'b1000); drop(3);
    cyc("rr_e", 4'b0010, 4'b0010); drop(1);
    chk("rr_cnt", 128'(conflict_cnt), STATS ? 128'd10 : 128'd0);

    // Store then load of the same word on consecutive cycles.
    set_lane(0, 1'b1, 1'b1, 14'h105, 32'hDEADBEEF);
    @(negedge clk);
    chk("st_gnt", 128'(sif.lane_gnt), 128'(4'b0001));
    chk("st_bank_en", 128'(sif.bank_en), 128'(4'b0010));
    chk("st_bank_we", 128'(sif.bank_we), 128'(4'b0010));
    chk("st_bank_addr", 128'(sif.bank_addr), 128'h41000);
    chk("st_bank_wd", 128'(sif.bank_wd), 128'hDEADBEEF_00000000);
    tick();
    chk("st_rvalid", 128'(sif.lane_rvalid), 128'(4'b0000));
    drop(0);
    set_lane(2, 1'b1, 1'b0, 14'h105, 32'h0);
    cyc("ld", 4'b0100, 4'b0100); chk_rd("ld_rd", 2, 32'hDEADBEEF); drop(2);
    cyc("ld_idle", 4'b0000, 4'b0000); chk_rd("ld_hold", 2, 32'hDEADBEEF);

    // Store and load to the same word in one cycle, ptr[0]=0.
    set_lane(0, 1'b1, 1'b1, 14'h8, 32'h5555AAAA);
    set_lane(1, 1'b1, 1'b0, 14'h8, 32'h0);
    cyc("mx1", 4'b0001, 4'b0000); drop(0);
    cyc("mx2", 4'b0010, 4'b0010); chk_rd("mx2_rd", 1, 32'h5555AAAA); drop(1);
    chk("mx_cnt", 128'(conflict_cnt), STATS ? 128'd11 : 128'd0);

    // Reset in the middle of a 4-way stall.
    reset_dut();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 14'(4 * i), 32'h0);
    cyc("rs1", 4'b0001, 4'b0001); drop(0);
    cyc("rs2", 4'b0010, 4'b0010); drop(1);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_gnt", 128'(sif.lane_gnt), 128'(4'b0000));
    chk("rs_bank_en", 128'(sif.bank_en), 128'(4'b0000));
    chk("rs_bank_we", 128'(sif.bank_we), 128'(4'b0000));
    tick();
    chk("rs_rvalid", 128'(sif.lane_rvalid), 128'(4'b0000));
    chk("rs_rdata", 128'(sif.lane_rdata), 128'h0);
    chk("rs_cnt", 128'(conflict_cnt), 128'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b0, 14'(4 * i), 32'h0);
    cyc("rs_first", 4'b0001, 4'b0001); chk_rd("rs_first_rd", 0, 32'hA0);
    chk("rs_first_cnt", 128'(conflict_cnt), STATS ? 128'd3 : 128'd0);
    sif.lane_req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
